// File: rtl/note_display_ctrl_pkg.sv
// Shared types and tables for the note display controller.
// Holds PS/2 prefix bytes, the 21-key note map, segment patterns,
// and the parser/display state encodings.
package note_disp_pkg;

  localparam int unsigned NOTE_W    = 5;
  localparam int unsigned NUM_NOTES = 21;

  localparam logic [7:0] BREAK = 8'hF0;
  localparam logic [7:0] EXT   = 8'hE0;

  typedef logic [NOTE_W-1:0] note_idx_t;
  typedef logic [6:0]        seg_t;

  typedef enum logic [1:0] {P_IDLE, P_BREAK, P_EXT, P_EXT_BRK} parse_state_t;
  typedef enum logic [1:0] {D_BLANK, D_HELD, D_HOLD}           disp_state_t;

  typedef struct packed {
    logic      hit;
    note_idx_t idx;
  } key_hit_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_G     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;

  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;

  // Make code to note index; rows Q..U, A..J, Z..M
  function automatic key_hit_t key_map(input logic [7:0] code);
    key_hit_t r;
    r.hit = 1'b1;
    r.idx = 5'd0;
    case (code)
      8'h15: r.idx = 5'd0;
      8'h1D: r.idx = 5'd1;
      8'h24: r.idx = 5'd2;
      8'h2D: r.idx = 5'd3;
      8'h2C: r.idx = 5'd4;
      8'h35: r.idx = 5'd5;
      8'h3C: r.idx = 5'd6;
      8'h1C: r.idx = 5'd7;
      8'h1B: r.idx = 5'd8;
      8'h23: r.idx = 5'd9;
      8'h2B: r.idx = 5'd10;
      8'h34: r.idx = 5'd11;
      8'h33: r.idx = 5'd12;
      8'h3B: r.idx = 5'd13;
      8'h1A: r.idx = 5'd14;
      8'h22: r.idx = 5'd15;
      8'h21: r.idx = 5'd16;
      8'h2A: r.idx = 5'd17;
      8'h32: r.idx = 5'd18;
      8'h31: r.idx = 5'd19;
      8'h3A: r.idx = 5'd20;
      default: r.hit = 1'b0;
    endcase
    return r;
  endfunction

  function automatic seg_t letter_seg(input logic [2:0] l);
    seg_t s;
    case (l)
      3'd0:    s = SEG_C;
      3'd1:    s = SEG_D;
      3'd2:    s = SEG_E;
      3'd3:    s = SEG_F;
      3'd4:    s = SEG_G;
      3'd5:    s = SEG_A;
      3'd6:    s = SEG_B;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  function automatic seg_t digit_seg(input logic [3:0] d);
    seg_t s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/note_display_ctrl_if.sv
// Scan-byte input and display output bundle of the note display controller.
//   scan_code/scan_valid : PS/2 byte and its one-cycle strobe
//   hex_letter/hex_octave: active-low seven-segment digits
//   note_valid/note_idx  : displayed note status and index
//   note_event           : one-cycle pulse on a newly latched note
interface note_display_ctrl_if;
  logic [7:0] scan_code;
  logic       scan_valid;
  logic [6:0] hex_letter;
  logic [6:0] hex_octave;
  logic       note_valid;
  logic [4:0] note_idx;
  logic       note_event;

  modport master (
    output scan_code, scan_valid,
    input  hex_letter, hex_octave, note_valid, note_idx, note_event
  );

  modport slave (
    input  scan_code, scan_valid,
    output hex_letter, hex_octave, note_valid, note_idx, note_event
  );
endinterface

// File: rtl/note_display_ctrl_seg_decode.sv
// Combinational note index to {letter, octave} segment decode.
//   idx      : note index 0..20
//   letter_c : letter segments (C,d,E,F,g,A,b)
//   octave_c : octave digit segments (OCTAVE_BASE + row)
module note_seg_decode
  import note_disp_pkg::*;
#(
  parameter int unsigned OCTAVE_BASE = 3
) (
  input  note_idx_t idx,
  output seg_t      letter_c,
  output seg_t      octave_c
);

  logic [1:0] row;
  logic [2:0] col;

  // Split index into keyboard row and letter column without a divider
  always_comb begin
    row = 2'd0;
    col = 3'(idx);
    if (idx >= 5'd14) begin
      row = 2'd2;
      col = 3'(idx - 5'd14);
    end else if (idx >= 5'd7) begin
      row = 2'd1;
      col = 3'(idx - 5'd7);
    end
    letter_c = letter_seg(col);
    octave_c = digit_seg(4'(OCTAVE_BASE) + 4'(row));
  end

endmodule

// File: rtl/note_display_ctrl.sv
// PS/2 scan-code parser plus note display with post-release hold timer.
//   clk, reset : clock and async active-high reset
//   bus        : slave side of note_display_ctrl_if (scan input, display outputs)
module note_display_ctrl
  import note_disp_pkg::*;
#(
  parameter int unsigned OCTAVE_BASE = 3,
  parameter int unsigned HOLD_CYCLES = 25000000
) (
  input logic               clk,
  input logic               reset,
  note_display_ctrl_if.slave bus
);

  localparam int unsigned CNT_W = (HOLD_CYCLES == 0) ? 1 : $clog2(HOLD_CYCLES + 1);

  parse_state_t     p_state, p_next;
  disp_state_t      d_state, d_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  note_idx_t        idx_q, idx_next;
  logic             event_next;
  logic             make_c, release_c;
  key_hit_t         key;

  seg_t letter_c, octave_c;
  seg_t letter_d, octave_d;
  logic valid_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_state <= P_IDLE;
      d_state <= D_BLANK;
      cnt     <= '0;
      idx_q   <= '0;
    end else begin
      p_state <= p_next;
      d_state <= d_next;
      cnt     <= cnt_next;
      idx_q   <= idx_next;
    end
  end

  // Next state: prefix parser then display tracking
  always_comb begin
    p_next     = p_state;
    make_c     = 1'b0;
    release_c  = 1'b0;
    d_next     = d_state;
    cnt_next   = cnt;
    idx_next   = idx_q;
    event_next = 1'b0;
    key        = key_map(bus.scan_code);

    if (bus.scan_valid) begin
      case (p_state)
        P_IDLE: begin
          if (bus.scan_code == BREAK)    p_next = P_BREAK;
          else if (bus.scan_code == EXT) p_next = P_EXT;
          else                           make_c = 1'b1;
        end
        P_BREAK: begin
          release_c = 1'b1;
          p_next    = P_IDLE;
        end
        P_EXT: begin
          if (bus.scan_code == BREAK) p_next = P_EXT_BRK;
          else                        p_next = P_IDLE;
        end
        default: p_next = P_IDLE;
      endcase
    end

    case (d_state)
      D_BLANK: begin
        if (make_c && key.hit) begin
          d_next     = D_HELD;
          idx_next   = key.idx;
          event_next = 1'b1;
        end
      end
      D_HELD: begin
        // Typematic repeats of the shown key are swallowed
        if (make_c && key.hit && key.idx != idx_q) begin
          idx_next   = key.idx;
          event_next = 1'b1;
        end else if (release_c && key.hit && key.idx == idx_q) begin
          if (HOLD_CYCLES != 0) begin
            d_next   = D_HOLD;
            cnt_next = CNT_W'(HOLD_CYCLES);
          end else begin
            d_next = D_BLANK;
          end
        end
      end
      D_HOLD: begin
        // A new make wins over expiry on the same edge
        if (make_c && key.hit) begin
          d_next     = D_HELD;
          idx_next   = key.idx;
          event_next = 1'b1;
          cnt_next   = '0;
        end else if (cnt <= CNT_W'(1)) begin
          d_next   = D_BLANK;
          cnt_next = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: d_next = D_BLANK;
    endcase
  end

  note_seg_decode #(
    .OCTAVE_BASE(OCTAVE_BASE)
  ) u_decode (
    .idx     (idx_next),
    .letter_c(letter_c),
    .octave_c(octave_c)
  );

  // Output decode from next state so outputs land one cycle after the strobe
  always_comb begin
    valid_d  = (d_next != D_BLANK);
    letter_d = valid_d ? letter_c : SEG_BLANK;
    octave_d = valid_d ? octave_c : SEG_BLANK;
  end

  // Output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.hex_letter <= SEG_BLANK;
      bus.hex_octave <= SEG_BLANK;
      bus.note_valid <= 1'b0;
      bus.note_idx   <= '0;
      bus.note_event <= 1'b0;
    end else begin
      bus.hex_letter <= letter_d;
      bus.hex_octave <= octave_d;
      bus.note_valid <= valid_d;
      bus.note_idx   <= idx_next;
      bus.note_event <= event_next;
    end
  end

endmodule
